// File: rtl/pipe_pkg.sv
// Shared pipeline payload types and widths for the inter-stage registers.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// if_id_t is the IF/ID payload; id_ex_t and ex_mem_t carry later boundaries.
package pipe_pkg;

  typedef struct packed {
    logic [1:0]  format;
    logic [3:0]  opcode;
    logic [2:0]  reg1;
    logic [2:0]  reg2;
    logic [2:0]  reg_d;
    logic [2:0]  imm;
    logic        imm_flag;
    logic [15:0] jmp_loc;
  } if_id_t;

  localparam int     IF_ID_W   = $bits(if_id_t);
  localparam if_id_t IF_ID_NOP = '0;

  typedef struct packed {
    logic [1:0]  format;
    logic [3:0]  opcode;
    logic [2:0]  reg_d;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] jmp_loc;
  } id_ex_t;

  localparam int     ID_EX_W   = $bits(id_ex_t);
  localparam id_ex_t ID_EX_NOP = '0;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [2:0]  reg_d;
    logic [15:0] result;
  } ex_mem_t;

  localparam int      EX_MEM_W   = $bits(ex_mem_t);
  localparam ex_mem_t EX_MEM_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, usable as a generic perf/event counter.
// Latency: count updates on the edge after inc/clr.
// Backpressure: none; clr wins over inc, count sticks at all-ones.
//
// Ports: clk, rst (async active-high), inc (count event), clr (sync clear),
//        count (current value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready, optional skid entry, flush, stall counter.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: SKID=1 absorbs one extra beat and registers in_ready; SKID=0 passes out_ready to in_ready combinationally.
//
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream; flush drops held and incoming
//        beats; stall_cnt counts out_valid & !out_ready cycles; clr_cnt clears it.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = IF_ID_W,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             clr_cnt
);

  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic             in_xfer;
  logic             out_xfer;

  // in_ready is forced low while rst is high so nothing is accepted during reset.
  generate
    if (SKID != 0) begin : g_skid
      // Depends only on a flop: no ready->ready combinational path.
      assign in_ready = !rst && !skid_v;
    end else begin : g_noskid
      assign in_ready = !rst && (!main_v || out_ready);
    end
  endgenerate

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_v && out_ready;
  assign out_valid = main_v;
  assign out_data  = main_v ? main_d : NOP_VALUE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= NOP_VALUE;
      skid_d <= NOP_VALUE;
    end else if (flush) begin
      // Drops held beats and any beat accepted this cycle; an output
      // transfer this cycle has already been seen downstream.
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_xfer) begin
      // Main slot frees up: the oldest waiting beat (skid first) moves in.
      if (skid_v) begin
        main_v <= 1'b1;
        main_d <= skid_d;
        skid_v <= 1'b0;
      end else begin
        main_v <= in_xfer;
        if (in_xfer) begin
          main_d <= in_data;
        end
      end
    end else if ((SKID != 0) && in_xfer) begin
      // Main is stuck; park the incoming beat in the skid entry.
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (main_v && !out_ready),
    .clr   (clr_cnt),
    .count (stall_cnt)
  );

  // A skid entry without a main entry would reorder payloads.
  a_no_orphan_skid : assert property (@(posedge clk) disable iff (rst) !(skid_v && !main_v));

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [34:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [34:0]   out_data;
  logic          flush;
  logic [15:0]   stall_cnt;
  logic          clr_cnt;

  // CNT_W=3 copy shares all inputs with the main instance.
  logic          c3_in_ready;
  logic          c3_out_valid;
  logic [34:0]   c3_out_data;
  logic [2:0]    c3_stall_cnt;

  // SKID=0 instance with its own handshake inputs.
  logic          ns_in_valid;
  logic          ns_in_ready;
  logic [7:0]    ns_in_data;
  logic          ns_out_valid;
  logic          ns_out_ready;
  logic [7:0]    ns_out_data;
  logic [15:0]   ns_stall_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(35), .SKID(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
  );

  pipe_stage_skid #(.WIDTH(35), .SKID(1), .CNT_W(3)) u_c3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c3_in_ready), .in_data(in_data),
    .out_valid(c3_out_valid), .out_ready(out_ready), .out_data(c3_out_data),
    .flush(flush), .stall_cnt(c3_stall_cnt), .clr_cnt(clr_cnt)
  );

  pipe_stage_skid #(.WIDTH(8), .SKID(0), .CNT_W(16)) u_ns (
    .clk(clk), .rst(rst), .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_data(ns_in_data),
    .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_data(ns_out_data),
    .flush(1'b0), .stall_cnt(ns_stall_cnt), .clr_cnt(1'b0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b1;
    flush        = 1'b0;
    clr_cnt      = 1'b0;
    ns_in_valid  = 1'b0;
    ns_in_data   = '0;
    ns_out_ready = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Streaming 1..8 with no backpressure
    in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 35'(i);
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data",  64'(out_data),  64'(i));
      check("stream_ready", 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain", 64'(out_valid), 64'd0);
    check("stream_stall", 64'(stall_cnt), 64'd0);

    // Backpressure: A into main, B into skid, then hold
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 35'h155;
    step();
    check("bp_a_data",  64'(out_data), 64'h155);
    check("bp_a_ready", 64'(in_ready), 64'd1);
    in_data = 35'h0AA;
    step();
    in_valid = 1'b0;
    check("bp_skid_ready", 64'(in_ready),  64'd0);
    check("bp_skid_cnt",   64'(stall_cnt), 64'd1);
    step();
    step();
    step();
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    check("bp_hold_data",  64'(out_data),  64'h155);
    check("bp_hold_ready", 64'(in_ready),  64'd0);
    check("bp_stall4",     64'(stall_cnt), 64'd4);
    check("bp_stall4_c3",  64'(c3_stall_cnt), 64'd4);
    out_ready = 1'b1;
    #1;
    check("bp_deliver_a", 64'(out_data), 64'h155);
    step();
    check("bp_deliver_b", 64'(out_data), 64'h0AA);
    check("bp_b_valid",   64'(out_valid), 64'd1);
    check("bp_b_ready",   64'(in_ready),  64'd1);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush with both entries held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 35'h11;
    step();
    in_data = 35'h22;
    step();
    check("fl_pre_ready", 64'(in_ready), 64'd0);
    flush   = 1'b1;
    in_data = 35'h7;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_data",  64'(out_data),  64'd0);
    check("fl_ready", 64'(in_ready),  64'd1);
    check("fl_cnt_kept", 64'(stall_cnt), 64'd6);
    // Flush from empty with an input transfer in the same cycle
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 35'h7;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_in_dropped", 64'(out_valid), 64'd0);
    step();
    check("fl_no_7", 64'(out_data), 64'd0);

    // Counter saturation and clear priority
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("cnt_clr", 64'(stall_cnt), 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 35'h33;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("cnt_10",     64'(stall_cnt),    64'd10);
    check("cnt_sat_c3", 64'(c3_stall_cnt), 64'd7);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("cnt_clr_prio",    64'(stall_cnt),    64'd0);
    check("cnt_clr_prio_c3", 64'(c3_stall_cnt), 64'd0);

    // Async reset mid-stream, asserted between edges
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_data",  64'(out_data),  64'd0);
    check("ar_ready", 64'(in_ready),  64'd0);
    check("ar_cnt",   64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("ar_rel_ready", 64'(in_ready),  64'd1);
    check("ar_rel_valid", 64'(out_valid), 64'd0);

    // SKID=0 instance: combinational in_ready and bubble-free replace
    ns_in_valid  = 1'b1;
    ns_in_data   = 8'h5A;
    ns_out_ready = 1'b0;
    #1;
    check("ns_empty_ready", 64'(ns_in_ready), 64'd1);
    step();
    check("ns_full_data",  64'(ns_out_data), 64'h5A);
    check("ns_full_ready", 64'(ns_in_ready), 64'd0);
    ns_out_ready = 1'b1;
    ns_in_data   = 8'hA5;
    #1;
    check("ns_comb_ready", 64'(ns_in_ready), 64'd1);
    step();
    check("ns_replace_valid", 64'(ns_out_valid), 64'd1);
    check("ns_replace_data",  64'(ns_out_data),  64'hA5);
    ns_out_ready = 1'b0;
    ns_in_valid  = 1'b0;
    #1;
    check("ns_comb_block", 64'(ns_in_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
